counter_mod: RTL
================

# counter_mod

Parametrised successor to the team's 8-bit up/down counter. Generalises width, adds a programmable terminal value (limit), a wrap/saturate mode, an enable prescaler, a terminal-count pulse and sticky overflow/underflow flags. Used as a general-purpose event/timebase counter in control datapaths, wherever a simple counter needs a modulus other than 2^WIDTH.

## Interface
- WIDTH, 8: counter width in bits; must be at least 2.
- PRESC_W, 4: prescaler width; divide ratio is presc+1, range 1..2^PRESC_W.
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of count and prescaler
- load  input  1  synchronous load of value_in
- value_in  input  WIDTH  load value
- enable  input  1  count enable
- updown  input  1  0 = count up, 1 = count down
- limit  input  WIDTH  terminal value; count range is 0..limit
- mode  input  1  0 = wrap, 1 = saturate
- presc  input  PRESC_W  step every presc+1 enabled cycles
- clear_flags  input  1  clears ovf and unf
- value_out  output  WIDTH  current count (register)
- tc  output  1  terminal-count pulse (register)
- ovf  output  1  sticky overflow/up-saturation flag
- unf  output  1  sticky underflow/down-saturation flag

## Operation
- Reset (rst_n=0, asynchronous): value_out=0, prescaler count pcnt=0, tc=0, ovf=0, unf=0.
- Priority per edge: clear > load > step > hold.
- clear: value_out=0, pcnt=0, tc=0. Flags are untouched.
- load: acts regardless of enable. value_out = min(value_in, limit); pcnt=0; tc=0.
- Prescaler: pcnt advances only while enable=1. When pcnt==presc, a step occurs and pcnt returns to 0; otherwise pcnt+1. With presc=0, every enabled cycle is a step. enable=0 freezes pcnt.
- Step, with value_out > limit (limit lowered at runtime): value_out=limit in either direction, no tc, no flag.
- Step up:
  - value_out < limit: +1.
  - value_out == limit: wrap mode gives 0; saturate mode holds limit. In both modes tc=1 and ovf set.
- Step down:
  - value_out > 0: -1.
  - value_out == 0: wrap mode gives limit; saturate mode holds 0. In both modes tc=1 and unf set.
- limit=0: every step hits the terminal case. value_out stays 0; tc pulses on every step.
- tc is 1 only in the cycle after a terminal step edge; otherwise 0. A repeated saturating step re-asserts tc each step.
- clear_flags clears ovf and unf. If set and clear coincide on the same edge, set wins.
- Arithmetic is modulo 2^WIDTH internally; the limit compare prevents any natural 2^WIDTH wrap except when limit = 2^WIDTH-1.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- value_out, tc and flags update on the edge where the step/load/clear condition is sampled. They are visible the following cycle (1-cycle latency).
- The first step after enable rises occurs on the (presc+1)-th enabled edge.
- rst_n assertion mid-count clears all state immediately. Deassertion is synchronised externally.
- updown, mode, limit and presc may change any cycle; they take effect on the next edge.

## Structure
- Shared package counter_pkg:
  - MODE_WRAP=0, MODE_SAT=1
  - DIR_UP=0, DIR_DOWN=1
  - default WIDTH and PRESC_W constants
- Sub-module counter_prescaler (PRESC_W): inputs clk, rst_n, clr, enable, presc; output step.
- Top level holds the count register, limit compare, tc and flag registers.

## Test plan
- Reset/basic, WIDTH=8, limit=255, presc=0, up, wrap: 256 enabled cycles. Expect value_out 0..255 then 0; tc high one cycle after 255→0; ovf=1.
- Modulo and down, limit=9, updown=1, mode wrap, start at 0: expect 9,8,…,0,9. unf set at the 0→9 step; tc on that step only.
- Saturate, limit=5, up from 3: expect 4,5,5,5. tc every step at 5; ovf=1. Then clear_flags: ovf=0 next cycle, except when a saturating step coincides, in which case ovf stays 1.
- Prescaler, presc=3, enable held: value_out increments every 4th cycle. Drop enable for 2 cycles mid-period: step is delayed by exactly 2 cycles.
- Priority/bounds:
  - clear+load+step same edge gives 0.
  - load value_in=200 with limit=50 gives 50.
  - Lower limit to 20 while at 40 gives 20 on the next step, no tc.
- Async reset mid-count: value_out=123 with ovf=1, pulse rst_n low between edges. Outputs are 0 before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the counter_mod block and its prescaler.
package counter_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 4;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one step every presc+1 enabled cycles.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc,
    output logic               step
);

    logic [PRESC_W-1:0] pcnt;
    logic               hit;

    assign hit  = (pcnt == presc);
    assign step = enable && hit && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (enable) begin
            pcnt <= hit ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_mod.sv
// Up/down counter with programmable limit, wrap/saturate mode,
// enable prescaler, terminal-count pulse and sticky flags.
module counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [WIDTH-1:0]   value_in,
    input  logic               enable,
    input  logic               updown,
    input  logic [WIDTH-1:0]   limit,
    input  logic               mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clear_flags,
    output logic [WIDTH-1:0]   value_out,
    output logic               tc,
    output logic               ovf,
    output logic               unf
);

    logic             step;
    logic [WIDTH-1:0] nxt_val;
    logic             nxt_tc;
    logic             set_ovf;
    logic             set_unf;
    logic             saturate;

    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clear | load),
        .enable (enable),
        .presc  (presc),
        .step   (step)
    );

    assign saturate = (mode == MODE_SAT);

    always_comb begin
        nxt_val = value_out;
        nxt_tc  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (clear) begin
            nxt_val = '0;
        end else if (load) begin
            nxt_val = (value_in > limit) ? limit : value_in;
        end else if (step) begin
            // A limit lowered below the count pulls it back silently
            if (value_out > limit) begin
                nxt_val = limit;
            end else if (updown == DIR_UP) begin
                if (value_out == limit) begin
                    nxt_val = saturate ? limit : '0;
                    nxt_tc  = 1'b1;
                    set_ovf = 1'b1;
                end else begin
                    nxt_val = value_out + 1'b1;
                end
            end else begin
                if (value_out == '0) begin
                    nxt_val = saturate ? '0 : limit;
                    nxt_tc  = 1'b1;
                    set_unf = 1'b1;
                end else begin
                    nxt_val = value_out - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_out <= '0;
            tc        <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            value_out <= nxt_val;
            tc        <= nxt_tc;
            ovf       <= set_ovf | (ovf & ~clear_flags);
            unf       <= set_unf | (unf & ~clear_flags);
        end
    end

endmodule
